imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: N, 32, instruction word width in bits (multiple of 8).
REQ-002 Parameter: DEPTH, 64, instruction memory depth in words; write address width is 6 bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a program load.
REQ-006 len  input  7  number of words to load, sampled only when start is accepted.
REQ-007 abort  input  1  cancels a load in progress.
REQ-008 in_valid  input  1  byte stream valid.
REQ-009 in_data  input  8  byte stream data.
REQ-010 in_ready  output  1  byte accepted when in_valid and in_ready are both high at a rising edge.
REQ-011 we  output  1  instruction memory write enable.
REQ-012 waddr  output  6  instruction memory write word address.
REQ-013 wdata  output  N  instruction memory write data.
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  one-cycle pulse when the last word has been written.
REQ-016 error  output  1  one-cycle pulse flagging a rejected start.
REQ-017 cpu_reset  output  1  active-high hold-in-reset for the processor.

Function
REQ-018 States: IDLE, RECV, WRITE, DONE.
REQ-019 IDLE -> RECV when start=1 and 1 <= len <= DEPTH; the block latches len and clears the word counter and byte counter.
REQ-020 IDLE stays in IDLE when start=1 and (len=0 or len>DEPTH); error pulses the next cycle.
REQ-021 start while busy is ignored; error pulses one cycle later; the load continues unaffected.
REQ-022 RECV: in_ready=1; the block accepts bytes little-endian (first byte -> wdata[7:0]).
REQ-023 On acceptance of byte N/8 of a word, the next state is WRITE.
REQ-024 WRITE lasts exactly one cycle: we=1, waddr=word counter, wdata=assembled word, in_ready=0.
REQ-025 After WRITE: word counter increments; next state is DONE if the counter equals the latched len, else RECV.
REQ-026 DONE lasts one cycle: done=1, busy=0, then IDLE.
REQ-027 busy=1 in RECV and WRITE only.
REQ-028 Latency: the final byte accepted at edge k gives we high in cycle k+1 and done high in cycle k+2.
REQ-029 cpu_reset=1 from reset until the first DONE; thereafter it is 1 whenever busy=1, else 0.
REQ-030 abort in RECV or WRITE: next state IDLE; no further writes; done is not pulsed; partial word is discarded; cpu_reset stays 1 until a later load completes.
REQ-031 abort has priority over byte acceptance and over WRITE-to-DONE in the same cycle.
REQ-032 abort in IDLE or DONE is ignored.
REQ-033 in_valid while in_ready=0 is not consumed; the source holds the byte.
REQ-034 waddr never exceeds len-1; with len=64 the last address is 63 and no wrap occurs.

Reset
REQ-035 On reset low, immediately: state IDLE, counters 0, in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0, cpu_reset=1.
REQ-036 Reset mid-load discards all progress; the first-load-completed flag clears so cpu_reset stays 1 until a new DONE.

Structure
REQ-037 Package imem_loader_pkg holds the state enum, DEPTH, and BYTES_PER_WORD (N/8).
REQ-038 One sub-module, byte_assembler: shift-in register with byte counter that assembles N-bit words and flags word-complete.

Verification
REQ-039 Reset, then start with len=3 and 12 bytes streamed back to back: 00,00,00,f8 / 01,00,00,f8 / 02,00,00,f8 -> writes f8000000@0, f8000001@1, f8000002@2, done one cycle after the third we, cpu_reset falls with done.
REQ-040 len=64 with gapped in_valid -> 64 writes, addresses 0..63 in order, no wrap, single done pulse.
REQ-041 start with len=0, and separately with len=65 -> error pulse each time, busy stays 0, no we.
REQ-042 abort after 5 words of a len=10 load -> no further we, no done, cpu_reset stays 1; a subsequent len=2 load writes addresses 0 and 1 and then pulses done.
REQ-043 reset low mid-byte of word 3 -> all outputs take their reset values asynchronously; cpu_reset=1 even after a previously completed load.
REQ-044 start during RECV -> error pulse; the original load completes with the correct count.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// Defaults: 32-bit instruction words, 64-word memory.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WORD_BITS      = 32;
  localparam int DEPTH          = 64;
  localparam int BYTES_PER_WORD = WORD_BITS / 8;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word shift register; word_done flags the byte that completes a word.
// Zero latency on word_done; no backpressure of its own, shift_en is gated by the caller.
module byte_assembler #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         shift_en,
  input  logic [7:0]   byte_in,
  output logic [N-1:0] word,
  output logic         word_done
);

  localparam int BPW = N / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);

  logic [CW-1:0] cnt_q;

  assign word_done = shift_en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (shift_en) begin
      cnt_q <= word_done ? '0 : cnt_q + 1'b1;
    end
  end

  // Bytes enter at the top and migrate down, so the first byte ends in [7:0].
  generate
    if (N > 8) begin : g_shift
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          word <= '0;
        end else if (clear) begin
          word <= '0;
        end else if (shift_en) begin
          word <= {byte_in, word[N-1:8]};
        end
      end
    end else begin : g_single
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          word <= '0;
        end else if (clear) begin
          word <= '0;
        end else if (shift_en) begin
          word <= byte_in;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a byte stream into instruction memory and holds the CPU in reset meanwhile.
// Last byte at edge k -> we in cycle k+1, done in k+2; in_ready drops during WRITE and on abort.
module imem_loader #(
  parameter int N     = imem_loader_pkg::WORD_BITS,
  parameter int DEPTH = imem_loader_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     we,
  output logic [$clog2(DEPTH)-1:0] waddr,
  output logic [N-1:0]             wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_reset
);

  import imem_loader_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   word_cnt;
  logic            error_q, error_d;
  logic            loaded_q;
  logic            clear;
  logic            shift_en;
  logic            word_done;
  logic            len_ok;
  logic            last_word;
  logic [N-1:0]    word;

  byte_assembler #(.N(N)) u_byte_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .shift_en  (shift_en),
    .byte_in   (in_data),
    .word      (word),
    .word_done (word_done)
  );

  // Abort wins over a byte offered in the same cycle, so ready drops with it.
  assign in_ready  = (state_q == RECV) && !abort;
  assign shift_en  = in_ready && in_valid;
  assign len_ok    = (len != '0) && (len <= DEPTH_L);
  assign last_word = ((word_cnt + 1'b1) == len_q);

  always_comb begin
    state_d = state_q;
    error_d = 1'b0;
    clear   = 1'b0;
    we      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = RECV;
            clear   = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      RECV: begin
        busy    = 1'b1;
        error_d = start;
        if (abort) begin
          state_d = IDLE;
        end else if (word_done) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy    = 1'b1;
        we      = 1'b1;
        error_d = start;
        if (abort) begin
          state_d = IDLE;
        end else if (last_word) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
        end
      end
      DONE: begin
        done    = 1'b1;
        error_d = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      error_q  <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      if (clear) begin
        len_q    <= len;
        word_cnt <= '0;
      end else if ((state_q == WRITE) && !abort) begin
        word_cnt <= word_cnt + 1'b1;
      end
      // An aborted load leaves the memory image incomplete, so the CPU stays held.
      if (state_q == DONE) begin
        loaded_q <= 1'b1;
      end else if (busy && abort) begin
        loaded_q <= 1'b0;
      end
    end
  end

  assign error     = error_q;
  assign waddr     = word_cnt[AW-1:0];
  assign wdata     = word;
  assign cpu_reset = busy || !(loaded_q || done);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized byte-stream bench for imem_loader against a transaction-level reference model.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  len;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_reset;

  imem_loader #(.N(32), .DEPTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_reset (cpu_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a load is "active" from accepted start until the last word is written;
  // bytes accumulate into a word by byte position, a full word becomes a pending write.
  bit          m_active, m_wp, m_dp, m_errp, m_loaded;
  int          m_len, m_idx, m_cnt, m_waddr;
  logic [31:0] m_word, m_wword;

  int          we_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] mem_got [64];

  task automatic model_reset();
    m_active = 0; m_wp = 0; m_dp = 0; m_errp = 0; m_loaded = 0;
    m_len = 0; m_idx = 0; m_cnt = 0; m_waddr = 0;
    m_word = '0; m_wword = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit oa, owp, odp, n_dp, n_errp;
    if (!reset) begin
      model_reset();
      chk("rst_we", we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
    end else begin
      chk("we", we, m_wp);
      chk("busy", busy, m_active);
      chk("done", done, m_dp);
      chk("error", error, m_errp);
      chk("in_ready", in_ready, m_active && !m_wp && !abort);
      chk("cpu_reset", cpu_reset, m_active || !(m_loaded || m_dp));
      if (m_wp) begin
        chk("waddr", waddr, m_waddr);
        chk("wdata", wdata, m_wword);
      end
      if (we) begin
        we_cnt++;
        mem_got[waddr] = wdata;
      end
      if (done) done_cnt++;

      oa = m_active; owp = m_wp; odp = m_dp;
      n_dp = 0; n_errp = 0;
      if (oa && abort) begin
        m_active = 0; m_wp = 0; m_cnt = 0; m_word = '0; m_loaded = 0;
      end else if (owp) begin
        m_wp = 0;
        m_idx++;
        if (m_idx == m_len) begin
          m_active = 0;
          n_dp = 1;
        end
      end else if (oa && in_valid) begin
        m_word = m_word | (32'(in_data) << (8 * m_cnt));
        m_cnt++;
        if (m_cnt == 4) begin
          m_wp = 1; m_wword = m_word; m_waddr = m_idx;
          m_cnt = 0; m_word = '0;
        end
      end
      if (odp) m_loaded = 1;
      if (start) begin
        if (!oa && !odp && len >= 1 && len <= 64) begin
          m_active = 1; m_len = int'(len); m_idx = 0; m_cnt = 0; m_word = '0;
        end else begin
          n_errp = 1;
        end
      end
      m_dp = n_dp;
      m_errp = n_errp;
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic do_start(input logic [6:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("byte_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] fix [12];
  int base_we, base_done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    fix = '{8'h00, 8'h00, 8'h00, 8'hf8, 8'h01, 8'h00, 8'h00, 8'hf8,
            8'h02, 8'h00, 8'h00, 8'hf8};
    idle(3);
    @(posedge clk); #1 reset = 1'b1;
    idle(2);

    // Fixed three-word program streamed back to back.
    base_we = we_cnt; base_done = done_cnt;
    do_start(7'd3);
    for (int i = 0; i < 12; i++) send_byte(fix[i], 0);
    idle(4);
    chk("fix_w0", mem_got[0], 32'hf800_0000);
    chk("fix_w1", mem_got[1], 32'hf800_0001);
    chk("fix_w2", mem_got[2], 32'hf800_0002);
    chk("fix_we_cnt", we_cnt - base_we, 3);
    chk("fix_done_cnt", done_cnt - base_done, 1);

    // Rejected lengths.
    base_we = we_cnt;
    do_start(7'd0);
    idle(3);
    do_start(7'd65);
    idle(3);
    chk("badlen_we_cnt", we_cnt - base_we, 0);

    // Full-depth load with gapped valid.
    base_we = we_cnt; base_done = done_cnt;
    do_start(7'd64);
    for (int i = 0; i < 256; i++) send_byte(8'($urandom), $urandom_range(0, 2));
    idle(4);
    chk("full_we_cnt", we_cnt - base_we, 64);
    chk("full_done_cnt", done_cnt - base_done, 1);

    // Abort after five words, with a byte offered in the abort cycle.
    base_we = we_cnt; base_done = done_cnt;
    do_start(7'd10);
    for (int i = 0; i < 22; i++) send_byte(8'($urandom), 0);
    in_valid = 1'b1; in_data = 8'($urandom); abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    idle(4);
    chk("abort_we_cnt", we_cnt - base_we, 5);
    chk("abort_done_cnt", done_cnt - base_done, 0);
    chk("abort_cpu_reset", cpu_reset, 1);
    do_start(7'd2);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), $urandom_range(0, 1));
    idle(4);
    chk("after_abort_done", done_cnt - base_done, 1);

    // Start request while a load is receiving.
    base_we = we_cnt;
    do_start(7'd5);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    do_start(7'd3);
    for (int i = 0; i < 14; i++) send_byte(8'($urandom), 0);
    idle(4);
    chk("busy_start_we_cnt", we_cnt - base_we, 5);

    // Random loads, with a stray abort in idle before each.
    for (int k = 0; k < 6; k++) begin
      int l;
      l = $urandom_range(1, 8);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      do_start(7'(l));
      for (int i = 0; i < 4 * l; i++) send_byte(8'($urandom), $urandom_range(0, 1));
      idle($urandom_range(1, 3));
    end

    // Reset asserted mid-cycle partway through the third word.
    do_start(7'd6);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_we", we, 0);
    chk("async_wdata", wdata, 0);
    chk("async_cpu_reset", cpu_reset, 1);
    idle(2);
    reset = 1'b1;
    idle(2);
    do_start(7'd1);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
